// File: rtl/search_ram_loader.sv
// search_ram_loader: fills a RAM with a saturating, non-decreasing ramp
// (base, base+step, ...) and then gates search start requests to a
// downstream binary search while the table is complete.
module search_ram_loader #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] base,
  input  logic [3:0]        step,
  input  logic              start_req,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              ready,
  output logic              search_start
);

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [3:0]          stp_q, stp_d;
  logic                start_q;
  logic [DATA_W:0]     sum;

  logic                wr_en_d, busy_d, ready_d, search_start_d;
  logic [ADDR_W-1:0]   wr_addr_d;
  logic [DATA_W-1:0]   wr_data_d;

  // One extra bit catches overflow so the ramp clamps instead of wrapping.
  assign sum = {1'b0, acc_q} + {{(DATA_W - 3){1'b0}}, stp_q};

  // State and datapath registers, plus start_req history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      acc_q   <= '0;
      stp_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
      stp_q   <= stp_d;
      start_q <= start_req;
    end
  end

  // Next-state and datapath update; load is ignored while filling.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    acc_d   = acc_q;
    stp_d   = stp_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (load) begin
          state_d = StFill;
          acc_d   = base;
          stp_d   = step;
          addr_d  = '0;
        end
      end
      StFill: begin
        acc_d = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
        if (addr_q == {ADDR_W{1'b1}}) begin
          // Last entry written: hold addr so nothing wraps into a second pass.
          state_d = StDone;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs, decoded from the current state.
  always_comb begin
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr;
    wr_data_d      = wr_data;
    busy_d         = 1'b0;
    ready_d        = 1'b0;
    unique case (state_q)
      StFill: begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = acc_q;
        busy_d    = 1'b1;
      end
      StDone:  ready_d = 1'b1;
      default: ;
    endcase
    // A rise that collides with a restart, or arrives while not ready, is dropped.
    search_start_d = (state_q == StDone) && ready && !load && start_req && !start_q;
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      busy         <= 1'b0;
      ready        <= 1'b0;
      search_start <= 1'b0;
    end else begin
      wr_en        <= wr_en_d;
      wr_addr      <= wr_addr_d;
      wr_data      <= wr_data_d;
      busy         <= busy_d;
      ready        <= ready_d;
      search_start <= search_start_d;
    end
  end

endmodule

// File: tb/tb_search_ram_loader.sv
// Self-checking bench for search_ram_loader. Expected table entries come
// from min(base + i*step, 255); control outputs from the scenario timeline.
module tb_search_ram_loader;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          load;
  logic [DW-1:0] base;
  logic [3:0]    step;
  logic          start_req;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          ready;
  logic          search_start;

  int n_checks = 0;
  int n_pass   = 0;

  search_ram_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .load         (load),
    .base         (base),
    .step         (step),
    .start_req    (start_req),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .ready        (ready),
    .search_start (search_start)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference table entry: plain arithmetic ramp clamped at the top.
  function automatic logic [DW-1:0] entry(input logic [DW-1:0] b, input logic [3:0] s,
                                          input int i);
    int v;
    v = int'(b) + i * int'(s);
    if (v > 255) return 8'hFF;
    return v[DW-1:0];
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; load = 1'b0; start_req = 1'b0;
    base = 8'($urandom); step = 4'($urandom);
    #3;
    n_checks++;
    if ({wr_en, busy, ready, search_start, wr_addr, wr_data} !== '0)
      $display("FAIL reset_outputs got=%h want=0",
               {wr_en, busy, ready, search_start, wr_addr, wr_data});
    else n_pass++;
    tick(); tick();
    reset_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      n_checks++;
      if ({wr_en, busy, ready, search_start} !== 4'b0000)
        $display("FAIL reset_idle t=%0d got=%b want=0000", t, {wr_en, busy, ready, search_start});
      else n_pass++;
    end
  endtask

  // Full fill from IDLE or DONE with per-cycle checks of every write.
  task automatic test_fill(input logic [DW-1:0] b, input logic [3:0] s, input string name);
    base = b; step = s; start_req = 1'b0;
    load = 1'b1;
    tick();
    load = 1'b0;
    n_checks++;
    if ({wr_en, busy, search_start} !== 3'b000)
      $display("FAIL %s_load_edge got=%b want=000", name, {wr_en, busy, search_start});
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      n_checks++;
      if ({wr_en, busy, ready, search_start, wr_addr, wr_data} !==
          {4'b1100, AW'(i), entry(b, s, i)})
        $display("FAIL %s_write i=%0d got ctl=%b a=%0d d=%h want ctl=1100 a=%0d d=%h", name, i,
                 {wr_en, busy, ready, search_start}, wr_addr, wr_data, i, entry(b, s, i));
      else n_pass++;
    end
    tick();
    n_checks++;
    if ({wr_en, busy, ready, search_start} !== 4'b0010)
      $display("FAIL %s_ready got=%b want=0010", name, {wr_en, busy, ready, search_start});
    else n_pass++;
    tick();
    n_checks++;
    if ({wr_en, busy, ready, search_start} !== 4'b0010)
      $display("FAIL %s_ready_hold got=%b want=0010", name, {wr_en, busy, ready, search_start});
    else n_pass++;
  endtask

  task automatic test_busy_immunity();
    logic [DW-1:0] b;
    logic [3:0]    s;
    logic [3:0]    want;
    int            writes;
    b = 8'($urandom); s = 4'($urandom);
    reset_n = 1'b0; start_req = 1'b0; load = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    base = b; step = s; load = 1'b1;
    tick();  // edge 0 samples load
    writes = 0;
    for (int t = 1; t <= 66; t++) begin
      // Load sampled at edges 0..39, with step/base changed mid-fill to prove no recapture.
      if (t == 5) begin base = ~b; step = ~s; end
      if (t == 33) begin base = b; step = s; end
      if (t == 40) load = 1'b0;
      tick();
      if (wr_en) writes++;
      if (t <= 32) want = 4'b1100;
      else if (t == 33 || t == 66) want = 4'b0010;
      else want = 4'b1100;
      n_checks++;
      if ({wr_en, busy, ready, search_start} !== want)
        $display("FAIL immunity_ctl t=%0d got=%b want=%b", t, {wr_en, busy, ready, search_start},
                 want);
      else n_pass++;
      if (want[3]) begin
        n_checks++;
        if ({wr_addr, wr_data} !== {AW'(t <= 32 ? t - 1 : t - 34),
                                    entry(b, s, t <= 32 ? t - 1 : t - 34)})
          $display("FAIL immunity_data t=%0d got a=%0d d=%h want d=%h", t, wr_addr, wr_data,
                   entry(b, s, t <= 32 ? t - 1 : t - 34));
        else n_pass++;
      end
    end
    n_checks++;
    if (writes !== 2 * DEPTH)
      $display("FAIL immunity_count got=%0d want=%0d", writes, 2 * DEPTH);
    else n_pass++;
  endtask

  task automatic test_gating();
    logic prev;
    logic sr;
    start_req = 1'b0;
    tick();
    base = 8'($urandom); step = 4'($urandom);
    load = 1'b1;
    tick();
    load = 1'b0;
    // Rise during the fill and held through ready rising: never a pulse.
    for (int t = 0; t < DEPTH + 5; t++) begin
      if (t == 4) start_req = 1'b1;
      tick();
      n_checks++;
      if (search_start !== 1'b0 || busy !== (t < DEPTH))
        $display("FAIL gating_busy t=%0d got ss=%b busy=%b want ss=0 busy=%b", t, search_start,
                 busy, t < DEPTH);
      else n_pass++;
    end
    start_req = 1'b0;
    tick();
    start_req = 1'b1;
    tick();
    n_checks++;
    if ({ready, search_start} !== 2'b11)
      $display("FAIL gating_pulse got=%b want=11", {ready, search_start});
    else n_pass++;
    for (int t = 0; t < 3; t++) begin
      tick();
      n_checks++;
      if (search_start !== 1'b0)
        $display("FAIL gating_held t=%0d got=%b want=0", t, search_start);
      else n_pass++;
    end
    // Random request pattern while ready: pulse exactly on each sampled 0->1.
    prev = 1'b1;
    for (int t = 0; t < 40; t++) begin
      sr = 1'($urandom);
      start_req = sr;
      tick();
      n_checks++;
      if (search_start !== (sr & ~prev))
        $display("FAIL gating_random t=%0d got=%b want=%b", t, search_start, sr & ~prev);
      else n_pass++;
      prev = sr;
    end
  endtask

  task automatic test_collision();
    logic [DW-1:0] b;
    b = 8'($urandom);
    start_req = 1'b0;
    tick();
    base = b; step = 4'h1;
    load = 1'b1; start_req = 1'b1;
    tick();
    load = 1'b0;
    n_checks++;
    if (search_start !== 1'b0)
      $display("FAIL collision_no_pulse got=%b want=0", search_start);
    else n_pass++;
    tick();
    n_checks++;
    if ({wr_en, busy, ready, search_start, wr_addr, wr_data} !== {4'b1100, AW'(0), b})
      $display("FAIL collision_fill got ctl=%b a=%0d d=%h want ctl=1100 a=0 d=%h",
               {wr_en, busy, ready, search_start}, wr_addr, wr_data, b);
    else n_pass++;
    for (int t = 0; t < DEPTH; t++) tick();
    n_checks++;
    if ({wr_en, busy, ready, search_start} !== 4'b0010)
      $display("FAIL collision_done got=%b want=0010", {wr_en, busy, ready, search_start});
    else n_pass++;
    start_req = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    base = 8'($urandom); step = 4'($urandom);
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i <= 12; i++) tick();
    n_checks++;
    if ({wr_en, wr_addr} !== {1'b1, AW'(12)})
      $display("FAIL midfill_at12 got en=%b a=%0d want en=1 a=12", wr_en, wr_addr);
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({wr_en, busy, ready, search_start, wr_addr, wr_data} !== '0)
      $display("FAIL midfill_async got=%h want=0",
               {wr_en, busy, ready, search_start, wr_addr, wr_data});
    else n_pass++;
    tick(); tick();
    reset_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick();
      n_checks++;
      if ({wr_en, busy, ready} !== 3'b000)
        $display("FAIL midfill_quiet t=%0d got=%b want=000", t, {wr_en, busy, ready});
      else n_pass++;
    end
    test_fill(8'($urandom), 4'($urandom), "refill");
  endtask

  initial begin
    test_reset();
    test_fill(8'h10, 4'h2, "basic");
    test_fill(8'hF0, 4'hF, "saturate");
    test_fill(8'($urandom), 4'h0, "step0");
    for (int r = 0; r < 3; r++) test_fill(8'($urandom), 4'($urandom), "random");
    test_busy_immunity();
    test_gating();
    test_collision();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/search_ram_loader.md
SEARCH_RAM_LOADER -- requirements
Module: search_ram_loader

Interface
REQ-001 Parameter ADDR_W, default 5: RAM address width; the RAM depth is 2**ADDR_W entries (32 entries at the default).
REQ-002 Parameter DATA_W, default 8: RAM word width.
REQ-003 Port clk, input, 1: the single clock (CLOCK_50 at top level); all state updates on its rising edge.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port load, input, 1: fill request, level-sampled on each rising clk edge.
REQ-006 Port base, input, DATA_W: value written to entry 0.
REQ-007 Port step, input, 4: increment added between consecutive entries, zero-extended to DATA_W+1 bits.
REQ-008 Port start_req, input, 1: raw search request (already active-high, synchronised).
REQ-009 Port wr_en, output, 1: RAM write enable.
REQ-010 Port wr_addr, output, ADDR_W: RAM write address.
REQ-011 Port wr_data, output, DATA_W: RAM write data.
REQ-012 Port busy, output, 1: high while the fill is in progress.
REQ-013 Port ready, output, 1: high when RAM holds a complete, non-decreasing table.
REQ-014 Port search_start, output, 1: one-cycle start pulse to the downstream binary_search.

Function
REQ-015 The block SHALL implement the FSM states IDLE, FILL and DONE, all outputs registered.
REQ-016 IDLE: wr_en=0, busy=0, ready=0; load=1 SHALL capture base into acc, step into stp, clear addr to 0, and enter FILL.
REQ-017 FILL: each cycle SHALL drive wr_en=1, wr_addr=addr, wr_data=acc, busy=1, ready=0.
REQ-018 FILL update: addr SHALL increment by 1; acc SHALL take (acc+stp), saturated to 2**DATA_W-1 using a DATA_W+1-bit sum.
REQ-019 Saturation SHALL guarantee the table is non-decreasing; with step=0 every entry equals base.
REQ-020 FILL SHALL exit to DONE after the cycle writing address 2**ADDR_W-1; addr SHALL NOT wrap into a second write pass.
REQ-021 load asserted during FILL SHALL be ignored, with no restart and no recapture of base or step.
REQ-022 DONE: wr_en=0, busy=0, ready=1.
REQ-023 In DONE, load=1 SHALL restart exactly as from IDLE; ready SHALL drop in the first FILL cycle.
REQ-024 Latency: if load is sampled at edge k, the block SHALL write entries 0..31 in cycles k+1..k+32 and raise ready from edge k+33.
REQ-025 search_start SHALL pulse for exactly one cycle, one cycle after a rising edge of start_req (0->1 between consecutive samples) is sampled while ready=1.
REQ-026 Holding start_req high SHALL produce only one pulse.
REQ-027 A start_req rise while ready=0 SHALL be dropped and not queued; it SHALL still update the edge-detect history.
REQ-028 If load and a start_req rise are sampled in the same DONE cycle, the block SHALL begin the fill and SHALL NOT issue search_start.

Reset
REQ-029 reset_n=0 SHALL immediately (asynchronously) force state=IDLE, addr=0, acc=0, stp=0, the start_req history bit=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, ready=0, search_start=0.
REQ-030 Reset asserted mid-FILL SHALL abort the fill with no further writes; ready SHALL stay 0 until a new complete fill finishes.
REQ-031 After reset_n deasserts, the block SHALL take no action until load is sampled high.

Verification
REQ-032 Scenario, basic fill: base=8'h10, step=4'h2, pulse load -> wr_data 0x10,0x12,...,0x4E at addr 0..31 on 32 consecutive cycles, then ready=1 at k+33.
REQ-033 Scenario, saturation: base=8'hF0, step=4'hF -> data 0xF0, 0xFF, then 0xFF for all remaining entries; no wrap to small values.
REQ-034 Scenario, busy immunity: load held high for 40 cycles from IDLE -> exactly one fill of 32 writes, then a second fill starts from DONE while load remains high.
REQ-035 Scenario, gating: start_req rise while busy=1 -> no pulse; start_req held through ready rising -> no pulse; fresh 0->1 rise with ready=1 -> exactly one search_start cycle.
REQ-036 Scenario, reset mid-fill: reset_n low at write 12 -> wr_en=0 and ready=0 immediately; no writes after release until load; a new fill then completes normally.
REQ-037 Scenario, collision: load and a start_req rise in the same DONE cycle -> search_start stays 0, busy=1 next cycle.
